// File: rtl/bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bus_xfer_ctrl
// Purpose  : Sequences one register transfer on the shared 32-bit bus.
//            It drives the source select for a programmable settle time, then
//            pulses a single one-hot destination load enable.
// Revision : 1.0 - initial release
// ============================================================================
module bus_xfer_ctrl #(
   parameter int SETTLE_CYCLES = 1,
   parameter int COUNT_W       = 16
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               req_valid,
   input  logic [4:0]         req_src,
   input  logic [4:0]         req_dst,
   output logic               req_ready,
   output logic [4:0]         select_sig,
   output logic [23:0]        dst_load,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [COUNT_W-1:0] xfer_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_LOAD  = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   // Select code 31 is in the mux default range, so the bus reads 0 when idle
   localparam logic [4:0] c_SEL_IDLE = 5'd31;
   localparam logic [4:0] c_MAX_CODE = 5'd23;
   localparam logic [3:0] c_SETTLE   = 4'(SETTLE_CYCLES);

   state_t             r_state;
   logic [3:0]         r_cnt;
   logic [4:0]         r_src;
   logic [4:0]         r_dst;

   state_t             w_state_nxt;
   logic [3:0]         w_cnt_nxt;
   logic [4:0]         w_src_nxt;
   logic [4:0]         w_dst_nxt;
   logic [COUNT_W-1:0] w_count_nxt;
   logic               w_ready_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;
   logic               w_err_nxt;
   logic [4:0]         w_sel_nxt;
   logic [23:0]        w_load_nxt;

   // Next-state logic; outputs are decoded from the next state so they can be registered
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_src_nxt   = r_src;
      w_dst_nxt   = r_dst;
      w_count_nxt = xfer_count;

      case (r_state)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               w_src_nxt = req_src;
               w_dst_nxt = req_dst;
               if ((req_src > c_MAX_CODE) || (req_dst > c_MAX_CODE)) begin
                  w_state_nxt = S_ERR;
               end else begin
                  w_state_nxt = S_DRIVE;
                  w_cnt_nxt   = 4'd1;
               end
            end
         end
         S_DRIVE: begin
            // r_cnt numbers the DRIVE cycle currently in progress
            if (r_cnt >= c_SETTLE) begin
               w_state_nxt = S_LOAD;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         S_LOAD: begin
            w_state_nxt = S_IDLE;
            w_count_nxt = xfer_count + 1'b1;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_ready_nxt = (w_state_nxt == S_IDLE);
      w_busy_nxt  = (w_state_nxt != S_IDLE);
      w_done_nxt  = (w_state_nxt == S_LOAD);
      w_err_nxt   = (w_state_nxt == S_ERR);
      w_sel_nxt   = ((w_state_nxt == S_DRIVE) || (w_state_nxt == S_LOAD)) ? w_src_nxt : c_SEL_IDLE;
      w_load_nxt  = (w_state_nxt == S_LOAD) ? (24'd1 << w_dst_nxt) : 24'd0;
   end

   // State, captured request and registered outputs
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_src      <= 5'd0;
         r_dst      <= 5'd0;
         req_ready  <= 1'b1;
         select_sig <= c_SEL_IDLE;
         dst_load   <= 24'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         xfer_count <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_src      <= w_src_nxt;
         r_dst      <= w_dst_nxt;
         req_ready  <= w_ready_nxt;
         select_sig <= w_sel_nxt;
         dst_load   <= w_load_nxt;
         busy       <= w_busy_nxt;
         done       <= w_done_nxt;
         err        <= w_err_nxt;
         xfer_count <= w_count_nxt;
      end
   end

endmodule
`default_nettype wire
